// File: rtl/div_unit.sv
// Sequential 32-bit radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle.
// Build option: DIV_EARLY_ZERO_EN makes a zero divisor bypass the iteration loop.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        ready,
    output logic [63:0] result
);

    // state | meaning
    // IDLE  | waiting for start; operands are latched on acceptance
    // CALC  | count 0..31 retires one quotient bit per cycle, count 32 applies signs
    // DONE  | ready pulses with the new result, then back to IDLE
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        b_zero_q, b_zero_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic [31:0] a_abs, b_abs;
    logic [32:0] r_shift;
    logic        r_ge;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        b_zero_d = b_zero_q;
        ready_d  = 1'b0;
        result_d = result_q;

        a_abs   = (signed_div && a[31]) ? (32'h0 - a) : a;
        b_abs   = (signed_div && b[31]) ? (32'h0 - b) : b;
        r_shift = {rem_q, quo_q[31]};
        r_ge    = (r_shift >= {1'b0, dvs_q});
        quo_fix = q_neg_q ? (32'h0 - quo_q) : quo_q;
        rem_fix = r_neg_q ? (32'h0 - rem_q) : rem_q;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d  = CALC;
                    cnt_d    = 6'd0;
                    rem_d    = 32'h0;
                    quo_d    = a_abs;
                    dvs_d    = b_abs;
                    q_neg_d  = signed_div & (a[31] ^ b[31]);
                    r_neg_d  = signed_div & a[31];
                    b_zero_d = (b == 32'h0);
`ifdef DIV_EARLY_ZERO_EN
                    // Jump straight to the finalize count; the remainder is |a| as if iterated.
                    if (b == 32'h0) begin
                        cnt_d = 6'd32;
                        rem_d = a_abs;
                    end
`endif
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q[5]) begin
                    // A zero divisor leaves rem = |a|, so only the quotient needs overriding.
                    state_d  = DONE;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, b_zero_q ? 32'hFFFF_FFFF : quo_fix};
                end else begin
                    rem_d = r_ge ? (r_shift[31:0] - dvs_q) : r_shift[31:0];
                    quo_d = {quo_q[30:0], r_ge};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'h0;
            quo_q    <= 32'h0;
            dvs_q    <= 32'h0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= 64'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            b_zero_q <= b_zero_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operand pairs with hand-computed {HI, LO} results.
// Honours DIV_EARLY_ZERO_EN for the expected zero-divisor latency.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        ready;
    logic [63:0] result;

`ifdef DIV_EARLY_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   ready_cnt = 0;
    int   rc;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every ready pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (!rst && ready) begin
            exp_t e;
            ready_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_ready: got ready with result %h, expected no response", result);
            end else begin
                e = sb.pop_front();
                chk(e.name, result, e.res);
                chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic issue(input bit sg, input logic [31:0] aa, input logic [31:0] bb,
                         input bit push, input logic [63:0] res, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        signed_div = sg;
        a = aa;
        b = bb;
        if (push) begin
            e.res = res; e.acc = cyc + 1; e.lat = lat; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        bit busy_ok = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (ready) seen = 1'b1;
        end
        chk({name, "_ready_seen"}, 64'(seen), 64'd1);
        chk({name, "_busy_held"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic do_op(input bit sg, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [63:0] res, input int lat, input string name);
        issue(sg, aa, bb, 1'b1, res, lat, name);
        wait_ready(name);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'h0);
        rst = 1'b0;

        do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "u100_7");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "s_m7_2");
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33, "u_m7_2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, "s_ovf");
        @(negedge clk);
        chk("s_ovf_one_pulse", 64'(ready), 64'd0);
        do_op(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZLAT, "u_5_0");
        do_op(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, ZLAT, "s_m5_0");

        // Cancel at iteration 10: no response, previous result retained.
        #1 rc = ready_cnt;
        issue(1'b0, 32'd100, 32'd7, 1'b0, 64'h0, 0, "cancelled");
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel_idle", 64'(busy), 64'd0);
        chk("cancel_result_kept", result, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        chk("cancel_no_ready", 64'(ready_cnt), 64'(rc));
        do_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "u9_3");

        // Start while DONE is ignored.
        start = 1'b1; a = 32'd50; b = 32'd5; signed_div = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rc = ready_cnt;
        @(negedge clk);
        chk("done_start_ignored", 64'(busy), 64'd0);

        // Start together with cancel in IDLE is dropped.
        start = 1'b1; cancel = 1'b1; a = 32'd60; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_dropped", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        #1 chk("dropped_no_ready", 64'(ready_cnt), 64'(rc));

        // Start pulses during CALC must not disturb the in-flight divide.
        issue(1'b0, 32'd1000, 32'd10, 1'b1, {32'd0, 32'd100}, 33, "calc_restart");
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            start = 1'b1; signed_div = 1'b1; a = 32'd50; b = 32'd5;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_ready("calc_restart");

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        issue(1'b0, 32'd77, 32'd7, 1'b0, 64'h0, 0, "aborted");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_stays_idle", 64'(busy), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, expected bench to finish");
        $fatal(1);
    end

endmodule
